// File: rtl/execute_mdu.sv
// Execute stage: XLEN-wide ALU with MEM/WB operand forwarding, plus an
// iterative multiply/divide unit (RV M-subset) that holds the pipeline via
// stall_ex until its result is presented together with a one-cycle mdu_done.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   valid_ex, flush_ex              EX holds a real instruction / kill it
//   inst_ex, ALUOp_ex, ALUSrc_ex    decode controls from ID/EX
//   imm_out_ex, read_data*_ex       ID/EX operands
//   rs1_ex, rs2_ex, rd_mem, rd_wb   register indices used for forwarding
//   RegWrite_mem/_wb, ALU_result_mem, Result_wb   forwarding sources
//   ALU_result_ex, zero_ex          result to EX/MEM (combinational)
//   write_data_ex                   forwarded rs2 value for stores
//   stall_ex                        hold front end, bubble into EX/MEM
//   mdu_done                        one-cycle pulse when an M-op result is shown
module execute_mdu #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_ex,
  input  logic            flush_ex,
  input  logic [31:0]     inst_ex,
  input  logic [1:0]      ALUOp_ex,
  input  logic            ALUSrc_ex,
  input  logic [XLEN-1:0] imm_out_ex,
  input  logic [XLEN-1:0] read_data1_ex,
  input  logic [XLEN-1:0] read_data2_ex,
  input  logic [4:0]      rs1_ex,
  input  logic [4:0]      rs2_ex,
  input  logic [4:0]      rd_mem,
  input  logic [4:0]      rd_wb,
  input  logic            RegWrite_mem,
  input  logic            RegWrite_wb,
  input  logic [XLEN-1:0] ALU_result_mem,
  input  logic [XLEN-1:0] Result_wb,
  output logic [XLEN-1:0] ALU_result_ex,
  output logic [XLEN-1:0] write_data_ex,
  output logic            zero_ex,
  output logic            stall_ex,
  output logic            mdu_done
);

  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [6:0] F7_MEXT  = 7'b0000001;
  localparam logic [SHW-1:0] LAST_STEP = SHW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [2:0] funct3;
  logic [6:0] funct7;
  assign funct3 = inst_ex[14:12];
  assign funct7 = inst_ex[31:25];

  // Register-index fields are supplied separately on rs*/rd* ports.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst_ex[24:15], inst_ex[11:7]};

  // Operand forwarding: MEM has priority over WB; x0 never forwards.
  logic [XLEN-1:0] fwd_a, fwd_b, op_b;
  always_comb begin
    fwd_a = read_data1_ex;
    if (RegWrite_mem && (rd_mem != 5'd0) && (rd_mem == rs1_ex))
      fwd_a = ALU_result_mem;
    else if (RegWrite_wb && (rd_wb != 5'd0) && (rd_wb == rs1_ex))
      fwd_a = Result_wb;
  end

  always_comb begin
    fwd_b = read_data2_ex;
    if (RegWrite_mem && (rd_mem != 5'd0) && (rd_mem == rs2_ex))
      fwd_b = ALU_result_mem;
    else if (RegWrite_wb && (rd_wb != 5'd0) && (rd_wb == rs2_ex))
      fwd_b = Result_wb;
  end

  assign op_b          = ALUSrc_ex ? imm_out_ex : fwd_b;
  assign write_data_ex = fwd_b;

  // Single-cycle ALU.
  logic [SHW-1:0]         shamt;
  logic signed [XLEN-1:0] sra_res;
  logic                   slt_bit, sltu_bit;
  logic [XLEN-1:0]        alu_res;

  assign shamt    = op_b[SHW-1:0];
  assign sra_res  = $signed(fwd_a) >>> shamt;
  assign slt_bit  = $signed(fwd_a) < $signed(op_b);
  assign sltu_bit = fwd_a < op_b;

  always_comb begin
    alu_res = '0;
    case (ALUOp_ex)
      2'b00: alu_res = fwd_a + op_b;
      2'b01: alu_res = fwd_a - op_b;
      2'b10: begin
        case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE)     alu_res = fwd_a + op_b;
            else if (funct7 == F7_ALT) alu_res = fwd_a - op_b;
          end
          3'b001: if (funct7 == F7_BASE) alu_res = fwd_a << shamt;
          3'b010: if (funct7 == F7_BASE) alu_res = XLEN'(slt_bit);
          3'b011: if (funct7 == F7_BASE) alu_res = XLEN'(sltu_bit);
          3'b100: if (funct7 == F7_BASE) alu_res = fwd_a ^ op_b;
          3'b101: begin
            if (funct7 == F7_BASE)     alu_res = fwd_a >> shamt;
            else if (funct7 == F7_ALT) alu_res = sra_res;
          end
          3'b110: if (funct7 == F7_BASE) alu_res = fwd_a | op_b;
          default: if (funct7 == F7_BASE) alu_res = fwd_a & op_b;
        endcase
      end
      default: begin
        // Immediate forms: only inst[30] matters (SRAI vs SRLI).
        case (funct3)
          3'b000:  alu_res = fwd_a + op_b;
          3'b001:  alu_res = fwd_a << shamt;
          3'b010:  alu_res = XLEN'(slt_bit);
          3'b011:  alu_res = XLEN'(sltu_bit);
          3'b100:  alu_res = fwd_a ^ op_b;
          3'b101:  alu_res = inst_ex[30] ? sra_res : (fwd_a >> shamt);
          3'b110:  alu_res = fwd_a | op_b;
          default: alu_res = fwd_a & op_b;
        endcase
      end
    endcase
  end

  // M-extension decode; funct3 001/010 are answered as 0 in a single cycle.
  logic is_mext, mop_multi, is_div_op, signed_op, div_zero, accept;
  assign is_mext   = valid_ex && (inst_ex[6:0] == OPC_OP) && (funct7 == F7_MEXT);
  assign mop_multi = is_mext && (funct3 != 3'b001) && (funct3 != 3'b010);
  assign is_div_op = funct3[2];
  assign signed_op = (funct3 == 3'b100) || (funct3 == 3'b110);
  assign div_zero  = is_div_op && (fwd_b == '0);

  state_t          state;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] acc_hi, acc_lo, mcand;
  logic [2:0]      op_f3;
  logic            neg_q, neg_r, div0;

  assign accept = (state == S_IDLE) && mop_multi && !flush_ex;

  // Operand magnitudes and sign flags captured at acceptance.
  logic            a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  assign a_neg = signed_op && fwd_a[XLEN-1];
  assign b_neg = signed_op && fwd_b[XLEN-1];
  assign mag_a = a_neg ? (-fwd_a) : fwd_a;
  assign mag_b = b_neg ? (-fwd_b) : fwd_b;

  // One iteration: shift-add for multiply, restoring subtract for divide.
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [XLEN-1:0] step_hi, step_lo;
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand};
    step_hi   = mul_sum[XLEN:1];
    step_lo   = {mul_sum[0], acc_lo[XLEN-1:1]};
    if (op_f3[2]) begin
      if (!div_diff[XLEN]) begin
        step_hi = div_diff[XLEN-1:0];
        step_lo = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        step_hi = div_shift[XLEN-1:0];
        step_lo = {acc_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  // Final selection with sign fix; divide-by-zero keeps the raw dividend in acc_lo.
  logic [XLEN-1:0] mdu_res;
  always_comb begin
    mdu_res = '0;
    case (op_f3)
      3'b000:         mdu_res = acc_lo;
      3'b011:         mdu_res = acc_hi;
      3'b100, 3'b101: mdu_res = div0 ? '1 : (neg_q ? (-acc_lo) : acc_lo);
      3'b110, 3'b111: mdu_res = div0 ? acc_lo : (neg_r ? (-acc_hi) : acc_hi);
      default:        mdu_res = '0;
    endcase
  end

  // MDU control FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mcand    <= '0;
      op_f3    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
      mdu_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          mdu_done <= 1'b0;
          if (accept) begin
            cnt    <= '0;
            op_f3  <= funct3;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= div_zero;
            acc_hi <= '0;
            if (is_div_op) begin
              acc_lo <= div_zero ? fwd_a : mag_a;
              mcand  <= mag_b;
            end else begin
              acc_lo <= fwd_b;
              mcand  <= fwd_a;
            end
            if (div_zero) begin
              state    <= S_DONE;
              mdu_done <= 1'b1;
            end else begin
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (flush_ex) begin
            state    <= S_IDLE;
            mdu_done <= 1'b0;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + SHW'(1);
            if (cnt == LAST_STEP) begin
              state    <= S_DONE;
              mdu_done <= 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          mdu_done <= 1'b0;
        end
      endcase
    end
  end

  assign stall_ex = rst_n && (accept || (state == S_BUSY));

  always_comb begin
    ALU_result_ex = alu_res;
    if (state == S_DONE)
      ALU_result_ex = mdu_res;
    else if (is_mext)
      ALU_result_ex = '0;
  end

  assign zero_ex = (ALU_result_ex == '0);

endmodule

// File: tb/tb_execute_mdu.sv
// Directed bench for execute_mdu (XLEN=64): table of single-cycle ALU and
// forwarding vectors, then hand-written multi-cycle M-op sequences.
module tb_execute_mdu;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid_ex, flush_ex;
  logic [31:0]     inst_ex;
  logic [1:0]      ALUOp_ex;
  logic            ALUSrc_ex;
  logic [XLEN-1:0] imm_out_ex, read_data1_ex, read_data2_ex;
  logic [4:0]      rs1_ex, rs2_ex, rd_mem, rd_wb;
  logic            RegWrite_mem, RegWrite_wb;
  logic [XLEN-1:0] ALU_result_mem, Result_wb;
  logic [XLEN-1:0] ALU_result_ex, write_data_ex;
  logic            zero_ex, stall_ex, mdu_done;

  int n_checks = 0;
  int n_fail   = 0;

  execute_mdu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .valid_ex(valid_ex), .flush_ex(flush_ex),
    .inst_ex(inst_ex), .ALUOp_ex(ALUOp_ex), .ALUSrc_ex(ALUSrc_ex),
    .imm_out_ex(imm_out_ex), .read_data1_ex(read_data1_ex),
    .read_data2_ex(read_data2_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rd_mem(rd_mem), .rd_wb(rd_wb), .RegWrite_mem(RegWrite_mem),
    .RegWrite_wb(RegWrite_wb), .ALU_result_mem(ALU_result_mem),
    .Result_wb(Result_wb), .ALU_result_ex(ALU_result_ex),
    .write_data_ex(write_data_ex), .zero_ex(zero_ex), .stall_ex(stall_ex),
    .mdu_done(mdu_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [1:0]  aluop;
    logic        alusrc;
    logic [63:0] imm, rd1, rd2;
    logic [4:0]  rs1, rs2, rd_mem, rd_wb;
    logic        rw_mem, rw_wb;
    logic [63:0] alu_mem, res_wb, exp_res, exp_wd;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd0, 5'd1, f3, 5'd3, 7'b0010011};
  endfunction

  function automatic vec_t mk(input string nm, input logic [31:0] ins, input logic [1:0] op,
                              input logic src, input logic [63:0] imm, a, b, er);
    vec_t v;
    v.name = nm; v.inst = ins; v.aluop = op; v.alusrc = src; v.imm = imm;
    v.rd1 = a; v.rd2 = b; v.rs1 = 5'd1; v.rs2 = 5'd2; v.rd_mem = 5'd0; v.rd_wb = 5'd0;
    v.rw_mem = 1'b0; v.rw_wb = 1'b0; v.alu_mem = 64'h0; v.res_wb = 64'h0;
    v.exp_res = er; v.exp_wd = b;
    return v;
  endfunction

  task automatic idle_inputs();
    valid_ex = 1'b0; flush_ex = 1'b0; inst_ex = 32'h0000_0013; ALUOp_ex = 2'b00;
    ALUSrc_ex = 1'b0; imm_out_ex = '0; read_data1_ex = '0; read_data2_ex = '0;
    rs1_ex = 5'd1; rs2_ex = 5'd2; rd_mem = 5'd0; rd_wb = 5'd0;
    RegWrite_mem = 1'b0; RegWrite_wb = 1'b0; ALU_result_mem = '0; Result_wb = '0;
  endtask

  task automatic drive_mop(input logic [2:0] f3, input logic [63:0] a, b, input bit fwd);
    idle_inputs();
    valid_ex = 1'b1; inst_ex = rtype(7'b0000001, f3); ALUOp_ex = 2'b10;
    read_data1_ex = a; read_data2_ex = b;
    if (fwd) begin
      rs1_ex = 5'd5; rd_mem = 5'd5; RegWrite_mem = 1'b1; ALU_result_mem = a;
      read_data1_ex = 64'hDEAD_BEEF_DEAD_BEEF;
    end
  endtask

  // Called in the acceptance cycle T (sampled mid-cycle); follows to mdu_done.
  task automatic wait_mop(input string nm, input logic [63:0] exp, input int exp_stalls,
                          input bit scramble);
    int stalls = 0;
    int cyc = -1;
    for (int c = 0; c < 200; c++) begin
      if (c == 1 && scramble) begin
        ALU_result_mem = 64'h1234_5678_9ABC_DEF0;
        Result_wb      = 64'h0FED_CBA9_8765_4321;
      end
      if (stall_ex) stalls++;
      if (mdu_done) begin
        cyc = c;
        break;
      end
      @(negedge clk); #1;
    end
    chk({nm, "_done_seen"}, 64'(cyc >= 0), 64'd1);
    if (cyc >= 0) begin
      chk({nm, "_result"}, ALU_result_ex, exp);
      chk({nm, "_stall_at_done"}, 64'(stall_ex), 64'd0);
      chk({nm, "_done_cycle"}, 64'(cyc), 64'(exp_stalls));
      chk({nm, "_stall_cycles"}, 64'(stalls), 64'(exp_stalls));
    end
  endtask

  task automatic run_mop(input string nm, input logic [2:0] f3, input logic [63:0] a, b, exp,
                         input int exp_stalls, input bit fwd);
    @(negedge clk);
    drive_mop(f3, a, b, fwd);
    #1;
    wait_mop(nm, exp, exp_stalls, fwd);
    idle_inputs();
    @(negedge clk); #1;
    chk({nm, "_done_pulse_end"}, 64'(mdu_done), 64'd0);
  endtask

  initial begin
    vec_t v;
    int mdone_cnt, stall_cnt;

    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    // M-op present while in reset: stall and done must stay low.
    drive_mop(3'b000, 64'd3, 64'd4, 1'b0);
    #2;
    chk("reset_stall", 64'(stall_ex), 64'd0);
    chk("reset_done", 64'(mdu_done), 64'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle vectors.
    v = mk("fwd_mem", 32'h0000_0013, 2'b00, 1'b1, 64'h0, 64'h33, 64'h55, 64'h11);
    v.rs1 = 5'd5; v.rd_mem = 5'd5; v.rd_wb = 5'd5; v.rw_mem = 1'b1; v.rw_wb = 1'b1;
    v.alu_mem = 64'h11; v.res_wb = 64'h22;
    vq.push_back(v);
    v.name = "fwd_wb"; v.rd_mem = 5'd0; v.exp_res = 64'h22;
    vq.push_back(v);
    v.name = "fwd_x0"; v.rs1 = 5'd0; v.rd_wb = 5'd0; v.exp_res = 64'h33;
    vq.push_back(v);
    v = mk("fwd_b_store", 32'h0000_0013, 2'b00, 1'b1, 64'h8, 64'h10, 64'h55, 64'h18);
    v.rs2 = 5'd7; v.rd_wb = 5'd7; v.rw_wb = 1'b1; v.res_wb = 64'h44; v.exp_wd = 64'h44;
    vq.push_back(v);
    v = mk("fwd_b_alu", 32'h0000_0013, 2'b00, 1'b0, 64'h0, 64'h1, 64'h55, 64'h101);
    v.rs2 = 5'd7; v.rd_mem = 5'd7; v.rw_mem = 1'b1; v.alu_mem = 64'h100;
    v.rd_wb = 5'd7; v.rw_wb = 1'b1; v.res_wb = 64'h44; v.exp_wd = 64'h100;
    vq.push_back(v);
    vq.push_back(mk("sra", rtype(7'h20, 3'b101), 2'b10, 1'b0, 64'h0,
                    64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000));
    vq.push_back(mk("slt", rtype(7'h00, 3'b010), 2'b10, 1'b0, 64'h0,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1));
    vq.push_back(mk("sltu", rtype(7'h00, 3'b011), 2'b10, 1'b0, 64'h0,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0));
    vq.push_back(mk("sub_zero", rtype(7'h20, 3'b000), 2'b10, 1'b0, 64'h0, 64'd5, 64'd5, 64'd0));
    vq.push_back(mk("add_r", rtype(7'h00, 3'b000), 2'b10, 1'b0, 64'h0, 64'd3, 64'd4, 64'd7));
    vq.push_back(mk("and", rtype(7'h00, 3'b111), 2'b10, 1'b0, 64'h0, 64'hF0F0, 64'hFF00, 64'hF000));
    vq.push_back(mk("or", rtype(7'h00, 3'b110), 2'b10, 1'b0, 64'h0, 64'hF0F0, 64'hFF00, 64'hFFF0));
    vq.push_back(mk("xor", rtype(7'h00, 3'b100), 2'b10, 1'b0, 64'h0, 64'hF0F0, 64'hFF00, 64'h0FF0));
    vq.push_back(mk("sll_63", rtype(7'h00, 3'b001), 2'b10, 1'b0, 64'h0,
                    64'd1, 64'd63, 64'h8000_0000_0000_0000));
    vq.push_back(mk("sll_low_bits", rtype(7'h00, 3'b001), 2'b10, 1'b0, 64'h0, 64'd1, 64'd66, 64'd4));
    vq.push_back(mk("srl", rtype(7'h00, 3'b101), 2'b10, 1'b0, 64'h0,
                    64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000));
    vq.push_back(mk("srai", itype(7'h20, 3'b101), 2'b11, 1'b1, 64'h404,
                    64'hFFFF_FFFF_FFFF_FF00, 64'h99, 64'hFFFF_FFFF_FFFF_FFF0));
    vq.push_back(mk("slti", itype(7'h7F, 3'b010), 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'd0, 64'h99, 64'd0));
    vq.push_back(mk("sltiu", itype(7'h7F, 3'b011), 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'd0, 64'h99, 64'd1));
    vq.push_back(mk("addi_f7_ignored", itype(7'h20, 3'b000), 2'b11, 1'b1, 64'd5,
                    64'd3, 64'h99, 64'd8));
    vq.push_back(mk("sub_op01", 32'h0000_0013, 2'b01, 1'b0, 64'h0, 64'd10, 64'd3, 64'd7));
    vq.push_back(mk("unknown_r", rtype(7'h10, 3'b000), 2'b10, 1'b0, 64'h0, 64'd3, 64'd4, 64'd0));
    vq.push_back(mk("mext_f3_010", rtype(7'h01, 3'b010), 2'b10, 1'b0, 64'h0, 64'd3, 64'd4, 64'd0));

    foreach (vq[i]) begin
      @(negedge clk);
      valid_ex = 1'b1; flush_ex = 1'b0;
      inst_ex = vq[i].inst; ALUOp_ex = vq[i].aluop; ALUSrc_ex = vq[i].alusrc;
      imm_out_ex = vq[i].imm; read_data1_ex = vq[i].rd1; read_data2_ex = vq[i].rd2;
      rs1_ex = vq[i].rs1; rs2_ex = vq[i].rs2; rd_mem = vq[i].rd_mem; rd_wb = vq[i].rd_wb;
      RegWrite_mem = vq[i].rw_mem; RegWrite_wb = vq[i].rw_wb;
      ALU_result_mem = vq[i].alu_mem; Result_wb = vq[i].res_wb;
      #1;
      chk({vq[i].name, "_result"}, ALU_result_ex, vq[i].exp_res);
      chk({vq[i].name, "_zero"}, 64'(zero_ex), 64'(vq[i].exp_res == 64'd0));
      chk({vq[i].name, "_write_data"}, write_data_ex, vq[i].exp_wd);
      chk({vq[i].name, "_stall"}, 64'(stall_ex), 64'd0);
    end
    idle_inputs();

    // Multi-cycle M-ops.
    run_mop("mul", 3'b000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 65, 1'b1);
    run_mop("mulhu", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65, 1'b0);
    run_mop("div_neg", 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0);
    run_mop("rem_neg", 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
    run_mop("divu_by0", 3'b101, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
    run_mop("remu_by0", 3'b111, 64'd7, 64'd0, 64'd7, 1, 1'b0);
    run_mop("div_ovf", 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 65, 1'b0);
    run_mop("rem_ovf", 3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65, 1'b0);

    // Flush at T+10 of a DIV: stall drops at T+11, no completion.
    @(negedge clk);
    drive_mop(3'b100, 64'd100, 64'd7, 1'b0);
    #1;
    chk("flush_accept_stall", 64'(stall_ex), 64'd1);
    repeat (10) begin @(negedge clk); #1; end
    chk("flush_t10_stall", 64'(stall_ex), 64'd1);
    flush_ex = 1'b1;
    @(negedge clk); #1;
    idle_inputs();
    chk("flush_t11_stall", 64'(stall_ex), 64'd0);
    mdone_cnt = 0; stall_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk); #1;
      if (mdu_done) mdone_cnt++;
      if (stall_ex) stall_cnt++;
    end
    chk("flush_no_done", 64'(mdone_cnt), 64'd0);
    chk("flush_no_stall", 64'(stall_cnt), 64'd0);

    // Reset at T+20 of a MUL; the held MUL restarts after release.
    @(negedge clk);
    drive_mop(3'b000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
    repeat (20) begin @(negedge clk); #1; end
    chk("rst_t20_stall_before", 64'(stall_ex), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_stall_immediate", 64'(stall_ex), 64'd0);
    chk("rst_done_immediate", 64'(mdu_done), 64'd0);
    @(negedge clk); #1;
    chk("rst_stall_held", 64'(stall_ex), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    wait_mop("mul_after_reset", 64'hFFFF_FFFE_0000_0001, 65, 1'b0);
    idle_inputs();
    @(negedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
